camera_emulator: RTL
====================

CAMERA_EMULATOR -- requirements
Module: camera_emulator

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 320, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 240, active lines per frame.
REQ-003 SHALL have parameter H_BLANK, default 144, blank byte slots per line after active bytes.
REQ-004 SHALL have parameter V_SYNC, default 3, lines with vsync high.
REQ-005 SHALL have parameter V_BACK, default 17, lines between vsync and first active line.
REQ-006 SHALL have parameter V_FRONT, default 10, lines after last active line.
REQ-007 SHALL have parameter PCLK_DIV, default 2, clk_in cycles per pclk half-period, minimum 1.
REQ-008 SHALL have port clk_in, input, 1, sole clock, all logic on rising edge.
REQ-009 SHALL have port rst_in, input, 1, reset; synchronous, active-high.
REQ-010 SHALL have port enable_in, input, 1, high requests continuous frame generation.
REQ-011 SHALL have port pattern_in, input, 2, test pattern select.
REQ-012 SHALL have port pclk_out, output, 1, emulated camera pixel clock.
REQ-013 SHALL have port vsync_out, output, 1, frame sync, high during VSYNC state.
REQ-014 SHALL have port href_out, output, 1, high while active bytes are presented.
REQ-015 SHALL have port pixel_out, output, 8, byte data, RGB565, high byte first.
REQ-016 SHALL have port frame_done_out, output, 1, one-clk_in pulse at end of each frame's last active byte.
REQ-017 SHALL have port frame_count_out, output, 8, completed frames, wraps 255->0.

Function
REQ-018 SHALL toggle pclk_out every PCLK_DIV clk_in cycles continuously, independent of state.
REQ-019 SHALL change vsync_out, href_out and pixel_out only on the clk_in edge where pclk_out goes high->low (a "byte slot" boundary); values stable across the following pclk rising edge.
REQ-020 SHALL run states IDLE, VSYNC, VBACK, ACTIVE, VFRONT; one line = 2*H_ACTIVE + H_BLANK byte slots in every non-IDLE state.
REQ-021 SHALL leave IDLE for VSYNC at the first slot boundary with enable_in high.
REQ-022 SHALL sequence VSYNC (V_SYNC lines) -> VBACK (V_BACK lines) -> ACTIVE (V_ACTIVE lines) -> VFRONT (V_FRONT lines).
REQ-023 SHALL, at end of VFRONT, go to VSYNC if enable_in high, else IDLE; enable_in low mid-frame never truncates a frame.
REQ-024 SHALL in ACTIVE drive href_out high for the first 2*H_ACTIVE slots of each line, low for the H_BLANK slots.
REQ-025 SHALL emit per pixel x (0..H_ACTIVE-1), line y (0..V_ACTIVE-1): slot 2x = P[15:8], slot 2x+1 = P[7:0].
REQ-026 SHALL compute P: pattern 0 -> 16'hFFFF; 1 -> x zero-extended to 16 bits; 2 -> (x[4]^y[4]) ? 16'hFFFF : 16'h0000; 3 -> {frame_count_out, x[7:0]}.
REQ-027 SHALL latch pattern_in once on entry to VSYNC; changes mid-frame take effect next frame.
REQ-028 SHALL drive pixel_out 8'h00 whenever href_out is low.
REQ-029 SHALL pulse frame_done_out for exactly one clk_in cycle at the slot boundary where href_out falls after the last byte of line V_ACTIVE-1, and increment frame_count_out on the same cycle.
REQ-030 SHALL size all counters from parameters with no overflow for any legal setting.

Reset
REQ-031 SHALL, while rst_in high, force state IDLE, pclk_out 0, vsync_out 0, href_out 0, pixel_out 0, frame_done_out 0, frame_count_out 0, divider and slot/line counters 0.
REQ-032 SHALL honour rst_in in any state including mid-ACTIVE, with outputs at reset values the cycle after rst_in is sampled high.
REQ-033 SHALL first toggle pclk_out PCLK_DIV cycles after rst_in falls.

Verification (params H_ACTIVE=4, V_ACTIVE=3, H_BLANK=2, V_SYNC=1, V_BACK=1, V_FRONT=1, PCLK_DIV=1)
REQ-034 SHALL cover reset: rst_in high 5 cycles -> all outputs 0, pclk_out static low; after release pclk_out period 2 clk_in cycles.
REQ-035 SHALL cover pattern 0, enable_in high: 1 vsync line (10 slots), 1 back line, 3 lines each 8 href-high bytes of 8'hFF then 2 low slots; frame_done_out one pulse; frame_count_out 0->1.
REQ-036 SHALL cover pattern 1: line 0 bytes at pclk rising edges = 00,00,00,01,00,02,00,03.
REQ-037 SHALL cover enable_in dropped during ACTIVE line 1: lines 1-2 and front porch complete, then IDLE with vsync_out/href_out 0, no further href.
REQ-038 SHALL cover pattern_in 0->1 mid-ACTIVE: rest of frame remains 8'hFF; next frame shows pattern 1; rst_in mid-ACTIVE -> href_out 0 next cycle, frame_count_out 0.
REQ-039 SHALL cover wrap: 256 complete frames -> frame_count_out returns to 0, 256 frame_done_out pulses.

Source files
------------

// File: rtl/camera_emulator.sv
// camera_emulator: emulates a parallel-bus camera sensor (OV7670-style timing).
// A free-running divided pixel clock defines byte slots; a frame is VSYNC, back porch,
// active lines of RGB565 test-pattern bytes (high byte first), then front porch.
//
// Ports:
//   clk_in          - sole clock, rising edge
//   rst_in          - synchronous active-high reset
//   enable_in       - request continuous frame generation
//   pattern_in      - test pattern select, latched on entry to VSYNC
//   pclk_out        - emulated pixel clock
//   vsync_out       - high for the VSYNC lines
//   href_out        - high while active bytes are presented
//   pixel_out       - byte data, 8'h00 whenever href_out is low
//   frame_done_out  - one-cycle pulse after the last active byte of a frame
//   frame_count_out - completed frames, wraps 255 -> 0
module camera_emulator #(
    parameter int unsigned H_ACTIVE = 320,
    parameter int unsigned V_ACTIVE = 240,
    parameter int unsigned H_BLANK  = 144,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BACK   = 17,
    parameter int unsigned V_FRONT  = 10,
    parameter int unsigned PCLK_DIV = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       enable_in,
    input  logic [1:0] pattern_in,
    output logic       pclk_out,
    output logic       vsync_out,
    output logic       href_out,
    output logic [7:0] pixel_out,
    output logic       frame_done_out,
    output logic [7:0] frame_count_out
);
    localparam int unsigned ACT_SLOTS  = 2 * H_ACTIVE;
    localparam int unsigned LINE_SLOTS = ACT_SLOTS + H_BLANK;
    localparam int unsigned MAX_SB     = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
    localparam int unsigned MAX_AF     = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int unsigned MAX_LINES  = (MAX_SB > MAX_AF) ? MAX_SB : MAX_AF;
    localparam int unsigned SLOT_W     = (LINE_SLOTS > 1) ? $clog2(LINE_SLOTS) : 1;
    localparam int unsigned LINE_W     = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
    localparam int unsigned DIV_W      = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;

    typedef enum logic [2:0] {StIdle, StVsync, StVback, StActive, StVfront} state_e;

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [LINE_W-1:0]   last_line;
    logic [1:0]          pattern_q, pattern_d;
    logic [DIV_W-1:0]    div_q;
    logic                pclk_q;
    logic                vsync_q, href_q, frame_done_q;
    logic [7:0]          pixel_q, frame_count_q;

    logic                div_wrap, tick, frame_end;
    logic [15:0]         x16, px;
    logic                y4, href_d;
    logic [7:0]          pixel_d;

    // A byte slot boundary is the edge on which pclk falls.
    assign div_wrap  = (div_q == DIV_W'(PCLK_DIV - 1));
    assign tick      = div_wrap && pclk_q;
    assign frame_end = tick && (state_q == StActive) && (line_q == LINE_W'(V_ACTIVE - 1)) &&
                       (slot_q == SLOT_W'(ACT_SLOTS - 1));

    always_comb begin
        last_line = '0;
        unique case (state_q)
            StVsync:  last_line = LINE_W'(V_SYNC - 1);
            StVback:  last_line = LINE_W'(V_BACK - 1);
            StActive: last_line = LINE_W'(V_ACTIVE - 1);
            StVfront: last_line = LINE_W'(V_FRONT - 1);
            default:  last_line = '0;
        endcase
    end

    // Position (state, line, slot) of the slot that starts at the next boundary.
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        line_d    = line_q;
        pattern_d = pattern_q;
        if (state_q == StIdle) begin
            slot_d = '0;
            line_d = '0;
            if (enable_in) begin
                state_d   = StVsync;
                pattern_d = pattern_in;
            end
        end else if (slot_q == SLOT_W'(LINE_SLOTS - 1)) begin
            slot_d = '0;
            if (line_q == last_line) begin
                line_d = '0;
                unique case (state_q)
                    StVsync:  state_d = StVback;
                    StVback:  state_d = StActive;
                    StActive: state_d = StVfront;
                    StVfront: begin
                        if (enable_in) begin
                            state_d   = StVsync;
                            pattern_d = pattern_in;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                    default:  state_d = StIdle;
                endcase
            end else begin
                line_d = line_q + LINE_W'(1);
            end
        end else begin
            slot_d = slot_q + SLOT_W'(1);
        end
    end

    // Pixel value for the upcoming slot; x is the pixel index, y4 is line bit 4.
    always_comb begin
        x16    = 16'(slot_d >> 1);
        y4     = ((32'(line_d) >> 4) & 32'd1) != 32'd0;
        href_d = (state_d == StActive) && (32'(slot_d) < ACT_SLOTS);
        unique case (pattern_q)
            2'd0: px = 16'hFFFF;
            2'd1: px = x16;
            2'd2: px = (x16[4] ^ y4) ? 16'hFFFF : 16'h0000;
            2'd3: px = {frame_count_q, x16[7:0]};
        endcase
        pixel_d = href_d ? (slot_d[0] ? px[7:0] : px[15:8]) : 8'h00;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= StIdle;
            slot_q        <= '0;
            line_q        <= '0;
            pattern_q     <= '0;
            div_q         <= '0;
            pclk_q        <= 1'b0;
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            pixel_q       <= 8'h00;
            frame_done_q  <= 1'b0;
            frame_count_q <= 8'h00;
        end else begin
            frame_done_q <= frame_end;
            if (div_wrap) begin
                div_q  <= '0;
                pclk_q <= ~pclk_q;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
            if (tick) begin
                state_q   <= state_d;
                slot_q    <= slot_d;
                line_q    <= line_d;
                pattern_q <= pattern_d;
                vsync_q   <= (state_d == StVsync);
                href_q    <= href_d;
                pixel_q   <= pixel_d;
            end
            if (frame_end) begin
                frame_count_q <= frame_count_q + 8'd1;
            end
        end
    end

    assign pclk_out        = pclk_q;
    assign vsync_out       = vsync_q;
    assign href_out        = href_q;
    assign pixel_out       = pixel_q;
    assign frame_done_out  = frame_done_q;
    assign frame_count_out = frame_count_q;
endmodule
